// File: rtl/oct_scan_ctrl_pkg.sv
// rtl/oct_scan_ctrl_pkg.sv - shared constants and scan-state type for the octal display scanner
package oct_scan_ctrl_pkg;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [2:0] AN_OFF  = 3'b111;

    typedef enum logic [1:0] {
        IDLE,
        DIG0,
        DIG1,
        DIG2
    } scan_state_t;

endpackage

// File: rtl/oct_scan_timer.sv
// rtl/oct_scan_timer.sv - per-digit slot counter with ghost-suppression gap flag
module oct_scan_timer #(
    parameter int REFRESH_DIV = 50000,
    parameter int GAP         = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic slot_end,
    output logic gap_active
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    logic [CW-1:0] cnt;

    assign slot_end   = (cnt == CW'(REFRESH_DIV - 1));
    assign gap_active = (cnt < CW'(GAP));

    // Held at zero while not scanning so every slot sequence starts cleanly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!run || slot_end) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/oct_scan_ctrl.sv
// rtl/oct_scan_ctrl.sv - 3-digit octal display scan controller with frame-aligned double buffering
module oct_scan_ctrl
    import oct_scan_ctrl_pkg::*;
#(
    parameter int REFRESH_DIV = 50000,
    parameter int GAP         = 2
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       EN,
    input  logic       LOAD,
    input  logic [7:0] VALUE,
    input  logic       LZB,
    input  logic [6:0] DEC_SEG,
    output logic [2:0] DEC_A,
    output logic [2:0] AN,
    output logic [6:0] SEG,
    output logic       UPD_ACK
);

    scan_state_t state;
    scan_state_t state_nxt;

    logic [7:0] shadow;
    logic [7:0] active;
    logic       pending;
    logic       shown;
    logic       slot_end;
    logic       gap_active;
    logic       run;
    logic       frame_edge;
    logic       commit;
    logic       blank1;
    logic       blank2;

    assign run    = EN && (state != IDLE);
    assign blank2 = LZB && (active[7:6] == 2'd0);
    assign blank1 = blank2 && (active[5:3] == 3'd0);

    // Once a value has been shown, re-enabling resumes scanning without a fresh LOAD.
    assign frame_edge = EN && (((state == IDLE) && (pending || LOAD || shown)) ||
                               ((state == DIG2) && slot_end));
    assign commit     = frame_edge && (pending || LOAD);

    oct_scan_timer #(
        .REFRESH_DIV(REFRESH_DIV),
        .GAP        (GAP)
    ) u_timer (
        .clk       (CLK),
        .rst_n     (RST_N),
        .run       (run),
        .slot_end  (slot_end),
        .gap_active(gap_active)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        DEC_A     = 3'd0;
        AN        = AN_OFF;
        case (state)
            IDLE: begin
                if (frame_edge) state_nxt = DIG0;
            end
            DIG0: begin
                DEC_A = active[2:0];
                if (!gap_active) AN = 3'b110;
                if (!EN)           state_nxt = IDLE;
                else if (slot_end) state_nxt = DIG1;
            end
            DIG1: begin
                DEC_A = active[5:3];
                if (!gap_active && !blank1) AN = 3'b101;
                if (!EN)           state_nxt = IDLE;
                else if (slot_end) state_nxt = DIG2;
            end
            DIG2: begin
                DEC_A = {1'b0, active[7:6]};
                if (!gap_active && !blank2) AN = 3'b011;
                if (!EN)           state_nxt = IDLE;
                else if (slot_end) state_nxt = DIG0;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            shadow  <= 8'd0;
            active  <= 8'd0;
            pending <= 1'b0;
            shown   <= 1'b0;
            UPD_ACK <= 1'b0;
            SEG     <= SEG_OFF;
        end else begin
            UPD_ACK <= commit;
            SEG     <= run ? DEC_SEG : SEG_OFF;
            if (LOAD) shadow <= VALUE;
            // A LOAD landing exactly on the boundary bypasses the shadow.
            if (commit) begin
                active  <= LOAD ? VALUE : shadow;
                pending <= 1'b0;
                shown   <= 1'b1;
            end else if (LOAD) begin
                pending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_oct_scan_ctrl.sv
// tb/tb_oct_scan_ctrl.sv - self-checking bench for oct_scan_ctrl against a frame-time reference model
module tb_oct_scan_ctrl;

    localparam int DIV   = 8;
    localparam int GAP   = 2;
    localparam int FRAME = 3 * DIV;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       en    = 1'b0;
    logic       load  = 1'b0;
    logic       lzb   = 1'b0;
    logic [7:0] value = 8'd0;
    logic [6:0] dec_seg;
    logic [2:0] dec_a;
    logic [2:0] an;
    logic [6:0] seg;
    logic       upd_ack;
    logic [13:0] obs;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    function automatic logic [6:0] seg_lut(input logic [2:0] d);
        case (d)
            3'd0: return 7'h40;
            3'd1: return 7'h79;
            3'd2: return 7'h24;
            3'd3: return 7'h30;
            3'd4: return 7'h19;
            3'd5: return 7'h12;
            3'd6: return 7'h02;
            default: return 7'h78;
        endcase
    endfunction

    assign dec_seg = seg_lut(dec_a);
    assign obs     = {an, dec_a, seg, upd_ack};

    oct_scan_ctrl #(.REFRESH_DIV(DIV), .GAP(GAP)) dut (
        .CLK    (clk),
        .RST_N  (rst_n),
        .EN     (en),
        .LOAD   (load),
        .VALUE  (value),
        .LZB    (lzb),
        .DEC_SEG(dec_seg),
        .DEC_A  (dec_a),
        .AN     (an),
        .SEG    (seg),
        .UPD_ACK(upd_ack)
    );

    // Reference model: scanning tracked as a position within a whole frame.
    bit         m_scan;
    int         m_phase;
    logic [7:0] m_shadow;
    logic [7:0] m_active;
    bit         m_pending;
    bit         m_valid;
    logic [6:0] m_seg;
    bit         m_ack;

    function automatic logic [2:0] m_digit(input int slot);
        return 3'((int'(m_active) >> (3 * slot)) & 7);
    endfunction

    function automatic bit m_blank(input int slot);
        return lzb && (slot > 0) && (int'(m_active) < (1 << (3 * slot)));
    endfunction

    function automatic logic [13:0] m_expect();
        logic [2:0] e_an;
        logic [2:0] e_dec;
        int slot;
        slot  = m_phase / DIV;
        e_an  = 3'b111;
        e_dec = 3'd0;
        if (m_scan) begin
            e_dec = m_digit(slot);
            if ((m_phase % DIV) >= GAP && !m_blank(slot)) e_an = ~(3'b001 << slot);
        end
        return {e_an, e_dec, m_seg, m_ack};
    endfunction

    task automatic model_reset();
        m_scan = 0; m_phase = 0; m_shadow = 8'd0; m_active = 8'd0;
        m_pending = 0; m_valid = 0; m_seg = 7'h7F; m_ack = 0;
    endtask

    task automatic step();
        bit exit_idle;
        bit frame_end;
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            exit_idle = !m_scan && en && (m_pending || load || m_valid);
            frame_end = m_scan && en && (m_phase == FRAME - 1);
            m_seg = (m_scan && en) ? seg_lut(m_digit(m_phase / DIV)) : 7'h7F;
            m_ack = (exit_idle || frame_end) && (load || m_pending);
            if (m_ack) begin
                m_active  = load ? value : m_shadow;
                m_pending = 0;
                m_valid   = 1;
            end else if (load) begin
                m_shadow  = value;
                m_pending = 1;
            end
            if (!en) begin
                m_scan = 0; m_phase = 0;
            end else if (exit_idle) begin
                m_scan = 1; m_phase = 0;
            end else if (m_scan) begin
                m_phase = (m_phase + 1) % FRAME;
            end
        end
        #1;
    endtask

    task automatic advance_to(input int ph, output bit ok);
        ok = 0;
        for (int i = 0; i < 4 * FRAME; i++) begin
            if (m_scan && m_phase == ph) begin
                ok = 1;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            n_checks++;
            if (obs !== m_expect()) begin
                n_fail++;
                $display("FAIL reset: got %h want %h", obs, m_expect());
            end
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic();
        int acks = 0;
        en = 1'b1; value = 8'hA5; load = 1'b1;
        step();
        load = 1'b0;
        if (upd_ack) acks++;
        for (int i = 0; i < 3 * FRAME; i++) begin
            n_checks++;
            if (obs !== m_expect()) begin
                n_fail++;
                $display("FAIL basic ph=%0d: got %h want %h", m_phase, obs, m_expect());
            end
            step();
            if (upd_ack) acks++;
        end
        n_checks++;
        if (acks != 1) begin
            n_fail++;
            $display("FAIL basic_ack_count: got %0d want 1", acks);
        end
    endtask

    task automatic test_lzb();
        int  hi_lit = 0;
        int  d1_lit = 0;
        bit  seen = 0;
        lzb = 1'b1; value = 8'd5; load = 1'b1;
        step();
        load = 1'b0;
        for (int i = 0; i < 2 * FRAME && !seen; i++) begin
            seen = upd_ack;
            n_checks++;
            if (obs !== m_expect()) begin
                n_fail++;
                $display("FAIL lzb_wait: got %h want %h", obs, m_expect());
            end
            if (!seen) step();
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL lzb_update: got no UPD_ACK want one within %0d cycles", 2 * FRAME);
        end
        for (int i = 0; i < 2 * FRAME; i++) begin
            step();
            if (an[2:1] != 2'b11) hi_lit++;
            n_checks++;
            if (obs !== m_expect()) begin
                n_fail++;
                $display("FAIL lzb_on: got %h want %h", obs, m_expect());
            end
        end
        n_checks++;
        if (hi_lit != 0) begin
            n_fail++;
            $display("FAIL lzb_blank: got %0d upper-digit lit cycles want 0", hi_lit);
        end
        lzb = 1'b0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            step();
            if (!an[1]) d1_lit++;
            n_checks++;
            if (obs !== m_expect()) begin
                n_fail++;
                $display("FAIL lzb_off: got %h want %h", obs, m_expect());
            end
        end
        n_checks++;
        if (d1_lit != 2 * (DIV - GAP)) begin
            n_fail++;
            $display("FAIL lzb_off_d1: got %0d lit cycles want %0d", d1_lit, 2 * (DIV - GAP));
        end
    endtask

    task automatic test_double_buffer();
        bit ok;
        int acks = 0;
        advance_to(DIV + 3, ok);
        value = 8'o017; load = 1'b1;
        step();
        load = 1'b0;
        advance_to(2 * DIV + 1, ok);
        value = 8'o123; load = 1'b1;
        step();
        load = 1'b0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            if (upd_ack) acks++;
            n_checks++;
            if (obs !== m_expect()) begin
                n_fail++;
                $display("FAIL dbuf ph=%0d: got %h want %h", m_phase, obs, m_expect());
            end
            step();
        end
        n_checks++;
        if (!ok || acks != 1) begin
            n_fail++;
            $display("FAIL dbuf_ack: got %0d acks (sync %0d) want 1", acks, ok);
        end
    endtask

    task automatic test_bypass();
        bit ok;
        int acks = 0;
        advance_to(FRAME - 1, ok);
        value = 8'($urandom_range(64, 255)); load = 1'b1;
        step();
        load = 1'b0;
        for (int i = 0; i < FRAME; i++) begin
            if (upd_ack) acks++;
            n_checks++;
            if (obs !== m_expect()) begin
                n_fail++;
                $display("FAIL bypass ph=%0d: got %h want %h", m_phase, obs, m_expect());
            end
            step();
        end
        n_checks++;
        if (!ok || acks != 1 || dut.pending !== 1'b0) begin
            n_fail++;
            $display("FAIL bypass_ack: got acks=%0d pending=%b want acks=1 pending=0", acks, dut.pending);
        end
    endtask

    task automatic test_en_toggle();
        bit ok;
        advance_to(DIV + 4, ok);
        en = 1'b0;
        step();
        n_checks++;
        if (!ok || an !== 3'b111 || seg !== 7'h7F || obs !== m_expect()) begin
            n_fail++;
            $display("FAIL en_off: got an=%b seg=%h want an=111 seg=7f", an, seg);
        end
        for (int i = 0; i < 5; i++) begin
            step();
            n_checks++;
            if (obs !== m_expect()) begin
                n_fail++;
                $display("FAIL en_idle: got %h want %h", obs, m_expect());
            end
        end
        en = 1'b1;
        for (int i = 0; i < FRAME + 2; i++) begin
            step();
            n_checks++;
            if (obs !== m_expect()) begin
                n_fail++;
                $display("FAIL en_resume: got %h want %h", obs, m_expect());
            end
        end
    endtask

    task automatic test_async_reset();
        bit ok;
        advance_to(2 * DIV + 4, ok);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (!ok || an !== 3'b111 || seg !== 7'h7F || dec_a !== 3'd0 || upd_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: got an=%b seg=%h dec_a=%0d ack=%b want 111 7f 0 0",
                     an, seg, dec_a, upd_ack);
        end
        step();
        rst_n = 1'b1;
        for (int i = 0; i < FRAME; i++) begin
            step();
            n_checks++;
            if (obs !== m_expect() || an !== 3'b111) begin
                n_fail++;
                $display("FAIL post_reset_idle: got %h want %h", obs, m_expect());
            end
        end
        value = 8'h3C; load = 1'b1;
        step();
        load = 1'b0;
        for (int i = 0; i < FRAME; i++) begin
            n_checks++;
            if (obs !== m_expect()) begin
                n_fail++;
                $display("FAIL post_reset_load: got %h want %h", obs, m_expect());
            end
            step();
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 800; i++) begin
            en    = ($urandom_range(0, 19) != 0);
            load  = ($urandom_range(0, 11) == 0);
            value = 8'($urandom);
            if ($urandom_range(0, 49) == 0) lzb = ~lzb;
            step();
            n_checks++;
            if (obs !== m_expect() || $countones(~an) > 1) begin
                n_fail++;
                $display("FAIL random cyc=%0d: got %h want %h", i, obs, m_expect());
            end
        end
        load = 1'b0;
        en   = 1'b1;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_lzb();
        test_double_buffer();
        test_bypass();
        test_en_toggle();
        test_random();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
